sort_sequencer: RTL and testbench

- Controller that runs an in-place ascending bubble sort over a window of the pipeline's data memory.
- Drives that memory through a single shared request/ready port.
- The pipeline's control logic starts it with start/base_addr/len and waits for done.
- Compare/swap work is split into one memory access per state, so the memory can be shared and stalled.

---
 rtl/sort_sequencer.sv | 166 ++++++++++++++++
 tb/tb_sort_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sort_sequencer.sv
// In-place ascending bubble sort over a window of a shared data memory.
// One memory access per state so the port can be shared and stalled by mem_ready.
module sort_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  swap_count,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [2:0] {
        IDLE, RD_A, RD_B, CMP, WR_A, WR_B, PASS_END, DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic [LEN_W-1:0]  i_reg, i_next;
    logic [LEN_W-1:0]  limit_reg, limit_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [DATA_W-1:0] b_reg, b_next;
    logic              swapped_reg, swapped_next;
    logic [CNT_W-1:0]  swap_count_reg, swap_count_next;

    logic [ADDR_W-1:0] addr_i;
    logic [ADDR_W-1:0] addr_i1;
    logic              pass_last;

    // Window addresses wrap modulo 2^ADDR_W by plain truncation.
    assign addr_i    = base_reg + i_reg[ADDR_W-1:0];
    assign addr_i1   = addr_i + ADDR_W'(1);
    // True when the pair at i is the last one of this pass.
    assign pass_last = (i_reg + LEN_W'(1)) >= limit_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            i_reg          <= '0;
            limit_reg      <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            swapped_reg    <= 1'b0;
            swap_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            base_reg       <= base_next;
            i_reg          <= i_next;
            limit_reg      <= limit_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
            swapped_reg    <= swapped_next;
            swap_count_reg <= swap_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        base_next       = base_reg;
        i_next          = i_reg;
        limit_next      = limit_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        swapped_next    = swapped_reg;
        swap_count_next = swap_count_reg;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    base_next       = base_addr;
                    limit_next      = len - LEN_W'(1);
                    i_next          = '0;
                    swapped_next    = 1'b0;
                    swap_count_next = '0;
                    state_next      = (len <= LEN_W'(1)) ? DONE : RD_A;
                end
            end
            RD_A: begin
                mem_req  = 1'b1;
                mem_addr = addr_i;
                if (mem_ready) begin
                    a_next     = mem_rdata;
                    state_next = RD_B;
                end
            end
            RD_B: begin
                mem_req  = 1'b1;
                mem_addr = addr_i1;
                if (mem_ready) begin
                    b_next     = mem_rdata;
                    state_next = CMP;
                end
            end
            CMP: begin
                // Strict compare keeps equal elements in place, so the sort is stable.
                if (a_reg > b_reg) begin
                    state_next = WR_A;
                end else begin
                    i_next     = i_reg + LEN_W'(1);
                    state_next = pass_last ? PASS_END : RD_A;
                end
            end
            WR_A: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_i;
                mem_wdata = b_reg;
                if (mem_ready) begin
                    state_next = WR_B;
                end
            end
            WR_B: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_i1;
                mem_wdata = a_reg;
                if (mem_ready) begin
                    swapped_next = 1'b1;
                    if (swap_count_reg != '1) begin
                        swap_count_next = swap_count_reg + CNT_W'(1);
                    end
                    i_next     = i_reg + LEN_W'(1);
                    state_next = pass_last ? PASS_END : RD_A;
                end
            end
            PASS_END: begin
                if (!swapped_reg || (limit_reg == LEN_W'(1))) begin
                    state_next = DONE;
                end else begin
                    limit_next   = limit_reg - LEN_W'(1);
                    i_next       = '0;
                    swapped_next = 1'b0;
                    state_next   = RD_A;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);
    assign swap_count = swap_count_reg;

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: behavioural memory, reference bubble-sort model and
// a scoreboard of expected swap counts / busy lengths checked on each done pulse.
module tb_sort_sequencer;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 9;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  swap_count;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready = 1'b1;

    logic [DATA_W-1:0] mem [0:255];

    sort_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .swap_count(swap_count),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_we) mem[mem_addr] = mem_wdata;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Scoreboard: one entry per accepted start.
    int exp_swaps_q[$];
    int exp_cycles_q[$];

    int busy_cnt = 0, done_cnt = 0, we_seen = 0, req_seen = 0, bad_addr = 0, stall_bad = 0;
    bit rand_ready = 1'b0;
    bit wrap_mode = 1'b0;

    initial begin : monitor
        bit prev_done = 1'b0;
        bit prev_valid = 1'b0;
        bit prev_stall = 1'b0;
        logic [ADDR_W+DATA_W+1:0] prev_bus = '0;
        int es, ec;
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++; else busy_cnt = 0;
            if (mem_req) begin
                req_seen++;
                if (mem_we) we_seen++;
                if (wrap_mode && !(mem_addr inside {8'd254, 8'd255, 8'd0, 8'd1})) bad_addr++;
            end
            if (prev_valid && rst && prev_stall &&
                ({mem_req, mem_we, mem_addr, mem_wdata} !== prev_bus)) stall_bad++;
            if (prev_done) check("busy_after_done", busy, 0);
            if (done) begin
                done_cnt++;
                if (exp_swaps_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    es = exp_swaps_q.pop_front();
                    ec = exp_cycles_q.pop_front();
                    check("swap_count", swap_count, es);
                    if (ec >= 0) check("busy_cycles", busy_cnt, ec);
                end
            end
            mem_ready  = rand_ready ? ($urandom_range(0, 99) >= 40) : 1'b1;
            prev_done  = done;
            prev_valid = rst;
            prev_stall = mem_req && !mem_ready;
            prev_bus   = {mem_req, mem_we, mem_addr, mem_wdata};
        end
    end

    task automatic load(input int base, input int vals[$]);
        for (int k = 0; k < vals.size(); k++) mem[(base + k) % 256] = DATA_W'(vals[k]);
    endtask

    // Reference bubble sort with early exit; pushes expectations, runs, checks memory.
    task automatic run(input string name, input int base, input int n, input bit rnd);
        logic [DATA_W-1:0] a[$];
        logic [DATA_W-1:0] t;
        int comps = 0, sw = 0, ps = 0, d0;
        bit s;
        for (int k = 0; k < n; k++) a.push_back(mem[(base + k) % 256]);
        for (int lim = n - 1; lim >= 1; lim--) begin
            ps++;
            s = 1'b0;
            for (int i = 0; i < lim; i++) begin
                comps++;
                if (a[i] > a[i+1]) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                    sw++;
                    s = 1'b1;
                end
            end
            if (!s) break;
        end
        exp_swaps_q.push_back(sw);
        exp_cycles_q.push_back(rnd ? -1 : 3*comps + 2*sw + ps + 1);
        $display("run %s: base=%0d len=%0d compares=%0d swaps=%0d passes=%0d", name, base, n, comps, sw, ps);
        we_seen = 0; req_seen = 0; bad_addr = 0; stall_bad = 0;
        rand_ready = rnd;
        d0 = done_cnt;
        @(negedge clk);
        base_addr = ADDR_W'(base);
        len = LEN_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20000 && done_cnt == d0; c++) @(negedge clk);
        check({name, "_done_seen"}, done_cnt - d0, 1);
        if (done_cnt == d0) begin
            exp_swaps_q.delete();
            exp_cycles_q.delete();
        end
        rand_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < n; k++)
            check($sformatf("%s_mem[%0d]", name, (base + k) % 256), mem[(base + k) % 256], a[k]);
    endtask

    initial begin : stim
        int rv[$];
        for (int k = 0; k < 256; k++) mem[k] = DATA_W'(32'hA000_0000 + k);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_swap_count", swap_count, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b1;
        @(negedge clk);

        load(0, '{9, 3, 7, 1, 5});
        run("vec1", 0, 5, 1'b0);

        load(0, '{1, 3, 5, 7, 9});
        run("sorted", 0, 5, 1'b0);
        check("sorted_no_write", we_seen, 0);

        run("len0", 0, 0, 1'b0);
        check("len0_no_req", req_seen, 0);
        load(7, '{42});
        run("len1", 7, 1, 1'b0);
        check("len1_no_req", req_seen, 0);

        load(254, '{4, 3, 2, 1});
        wrap_mode = 1'b1;
        run("wrap", 254, 4, 1'b0);
        wrap_mode = 1'b0;
        check("wrap_addr_range", bad_addr, 0);

        load(0, '{9, 3, 7, 1, 5});
        run("vec1_stall", 0, 5, 1'b1);
        check("vec1_stall_stable", stall_bad, 0);

        rv.delete();
        for (int k = 0; k < 12; k++) rv.push_back(int'($urandom_range(0, 3)));
        load(100, rv);
        run("dups_stall", 100, 12, 1'b1);
        check("dups_stall_stable", stall_bad, 0);

        // Abort during the first swap's WR_A.
        load(0, '{9, 3, 7, 1, 5});
        exp_swaps_q.push_back(0);
        exp_cycles_q.push_back(0);
        @(negedge clk);
        base_addr = '0; len = LEN_W'(5); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && !(mem_req && mem_we); c++) @(negedge clk);
        check("abort_reached_write", mem_req && mem_we, 1);
        rst = 1'b0;
        @(negedge clk);
        exp_swaps_q.delete();
        exp_cycles_q.delete();
        check("abort_busy", busy, 0);
        check("abort_mem_req", mem_req, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_reset_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_reset_busy", busy, 0);
        load(0, '{9, 3, 7, 1, 5});
        run("after_abort", 0, 5, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
